// File: rtl/wave_capture_ctrl.sv
// Trigger/capture sequencer: fills one bank of a two-bank sample RAM after a trigger
// and swaps banks with the VGA scan only at frame start so the trace never tears.
module wave_capture_ctrl #(
  parameter int SAMPLES      = 640,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              trig_auto,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              frame_start,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_bank,
  output logic              armed,
  output logic              triggered,
  output logic              forced,
  output logic [1:0]        state_dbg
);

  // Handshake: adc_valid qualifies adc_data for exactly the clk it is high (no
  // back-pressure); wr_en qualifies wr_addr/wr_data one clk after that sample.

  localparam int CNT_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [ADDR_W-1:0]   cap_addr;

  logic real_trig, force_trig, take_trig, capture_wr, last_wr, swap;

  always_comb begin
    real_trig  = adc_valid & prev_valid & (prev < trig_level) & (adc_data >= trig_level);
    // A real crossing wins over a timeout landing on the same sample.
    force_trig = adc_valid & trig_auto & (tmo_cnt == CNT_MAX) & ~real_trig;
    take_trig  = (state == S_ARMED) & run & (real_trig | force_trig);
    capture_wr = (state == S_CAPTURE) & adc_valid;
    last_wr    = capture_wr & (cap_addr == LAST_ADDR);
    swap       = (state == S_FULL) & frame_start;

    state_next = state;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (!run)          state_next = S_IDLE;
        else if (take_trig) state_next = (SAMPLES == 1) ? S_FULL : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (last_wr) state_next = S_FULL;
      end
      S_FULL: begin
        if (frame_start) state_next = run ? S_ARMED : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      triggered  <= 1'b0;
      forced     <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      tmo_cnt    <= '0;
      cap_addr   <= '0;
    end else begin
      wr_en     <= 1'b0;
      triggered <= 1'b0;

      if ((state == S_ARMED) && run && adc_valid) begin
        prev       <= adc_data;
        prev_valid <= 1'b1;
        if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      // The triggering sample is itself the first sample of the trace.
      if (take_trig) begin
        wr_en     <= 1'b1;
        wr_addr   <= '0;
        wr_data   <= adc_data;
        cap_addr  <= ADDR_W'(1);
        triggered <= 1'b1;
        forced    <= force_trig;
      end

      if (capture_wr) begin
        wr_en    <= 1'b1;
        wr_addr  <= cap_addr;
        wr_data  <= adc_data;
        cap_addr <= cap_addr + ADDR_W'(1);
      end

      if ((state == S_IDLE) || swap) begin
        prev_valid <= 1'b0;
        tmo_cnt    <= '0;
      end

      if (swap) rd_bank <= ~rd_bank;
    end
  end

  assign wr_bank   = ~rd_bank;
  assign armed     = (state == S_ARMED);
  assign state_dbg = state;

endmodule
